// File: rtl/ls_sequencer.sv
// ls_sequencer: hands one load/store instruction at a time to the rf
// register-file/RAM datapath, waits for memory to settle, then retires it.
// While idle, the rf read ports belong to a debug read-back requester.
//
// Optional build macro: LS_SEQ_PERF_CNT_EN adds the saturating counters
// cnt_load, cnt_store and cnt_err for retired instructions.
//
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   instr_valid/instr_ready         instruction handshake
//   instr_op/rt/rb/imm              op (00 NOP, 01 LOAD, 10 STORE, 11 reserved),
//                                   data register, base register, offset
//   resp_valid/resp_ready           retirement handshake
//   resp_op, resp_err               op of the retired instruction, reserved flag
//   dbg_a, dbg_b, dbg_grant         debug read-back indices, read ports granted
//   rf_enable, rf_load_store        rf strobe (one cycle), 1 = load
//   rf_a, rf_b, rf_w, rf_din        rf register indices and offset
//   cnt_load/cnt_store/cnt_err      retirement counters (macro only)
module ls_sequencer #(
  parameter int unsigned DW       = 64,
  parameter int unsigned AW       = 5,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [1:0]    instr_op,
  input  logic [AW-1:0] instr_rt,
  input  logic [AW-1:0] instr_rb,
  input  logic [DW-1:0] instr_imm,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [1:0]    resp_op,
  output logic          resp_err,
  input  logic [AW-1:0] dbg_a,
  input  logic [AW-1:0] dbg_b,
  output logic          dbg_grant,
  output logic          rf_enable,
  output logic          rf_load_store,
  output logic [AW-1:0] rf_a,
  output logic [AW-1:0] rf_b,
  output logic [AW-1:0] rf_w,
  output logic [DW-1:0] rf_din
`ifdef LS_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]   cnt_load,
  output logic [15:0]   cnt_store,
  output logic [15:0]   cnt_err
`endif
);

  localparam int unsigned CW = 4;
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rb_q;
  logic          accept;

  // State and settle-counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          accept = 1'b1;
          if (instr_op == OP_LOAD || instr_op == OP_STORE) state_d = S_EXEC;
          else                                             state_d = S_RESP;
        end
      end
      S_EXEC: begin
        if (WAIT_CYC != 0) begin
          state_d = S_WAIT;
          cnt_d   = CW'(WAIT_CYC);
        end else begin
          state_d = S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read ports follow the debug requester only while idle
  assign instr_ready = (state_q == S_IDLE);
  assign dbg_grant   = (state_q == S_IDLE);
  assign rf_a        = dbg_grant ? dbg_a : rf_w;
  assign rf_b        = dbg_grant ? dbg_b : rb_q;

  // Registered rf controls and response; fields latch once on accept and
  // hold through WAIT/RESP so the rf and responder see stable values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_enable     <= 1'b0;
      rf_load_store <= 1'b0;
      rf_w          <= '0;
      rb_q          <= '0;
      rf_din        <= '0;
      resp_valid    <= 1'b0;
      resp_op       <= OP_NOP;
      resp_err      <= 1'b0;
    end else begin
      rf_enable  <= (state_d == S_EXEC);
      resp_valid <= (state_d == S_RESP);
      if (accept) begin
        rf_load_store <= (instr_op == OP_LOAD);
        rf_w          <= instr_rt;
        rb_q          <= instr_rb;
        rf_din        <= instr_imm;
        resp_op       <= instr_op;
        resp_err      <= (instr_op == OP_RSVD);
      end
    end
  end

`ifdef LS_SEQ_PERF_CNT_EN
  logic resp_hs;
  assign resp_hs = resp_valid && resp_ready;

  // Saturating retirement counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_load  <= '0;
      cnt_store <= '0;
      cnt_err   <= '0;
    end else if (resp_hs) begin
      if (resp_op == OP_LOAD && cnt_load != 16'hFFFF)   cnt_load  <= cnt_load + 16'd1;
      if (resp_op == OP_STORE && cnt_store != 16'hFFFF) cnt_store <= cnt_store + 16'd1;
      if (resp_op == OP_RSVD && cnt_err != 16'hFFFF)    cnt_err   <= cnt_err + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ls_sequencer.md
Name: ls_sequencer

Overview:
- Controller that sequences load/store instructions onto the rf register-file/RAM datapath.
- Accepts one instruction at a time over a valid/ready handshake and drives the rf control pins (enable, load_store, a, b, w, din) for exactly one cycle.
- Waits a configurable memory settle time, then returns a response over a second valid/ready handshake.
- When idle, arbitrates the rf read ports to a debug/read-back requester.

Parameters:
- DW, 64, data/immediate width (matches rf din).
- AW, 5, register index width.
- WAIT_CYC, 1, cycles held in WAIT after the rf enable pulse; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  sequencer can accept an instruction.
- instr_op  input  2  00 NOP, 01 LOAD, 10 STORE, 11 reserved.
- instr_rt  input  AW  STORE source register / LOAD destination register.
- instr_rb  input  AW  base register.
- instr_imm  input  DW  address offset.
- resp_valid  output  1  instruction retired.
- resp_ready  input  1  response consumed.
- resp_op  output  2  op of the retired instruction.
- resp_err  output  1  reserved op was retired.
- dbg_a, dbg_b  input  AW  read-back register indices.
- dbg_grant  output  1  rf read ports currently routed to dbg_a/dbg_b.
- rf_enable  output  1  to rf enable.
- rf_load_store  output  1  to rf load_store (1 = load).
- rf_a, rf_b, rf_w  output  AW  to rf a, b, w.
- rf_din  output  DW  to rf din (offset).

Behaviour:
- Reset (async, immediate):
  - state IDLE.
  - All registered outputs 0: rf_enable, rf_load_store, rf_w, rf_din, resp_valid, resp_op, resp_err.
  - Latched fields cleared; wait counter 0.
- Reset asserted mid-operation:
  - rf_enable drops immediately.
  - The in-flight instruction is dropped and produces no response.
- FSM states: IDLE, EXEC, WAIT, RESP.
- IDLE:
  - instr_ready=1, dbg_grant=1; rf_a=dbg_a and rf_b=dbg_b combinationally.
  - On instr_valid&&instr_ready, latch op/rt/rb/imm.
  - Next state: NOP or reserved -> RESP (resp_err=1 for reserved); LOAD/STORE -> EXEC.
- EXEC (exactly 1 cycle):
  - rf_enable=1; rf_load_store=(op==LOAD); rf_a=rt; rf_w=rt; rf_b=rb; rf_din=imm.
  - Next state: WAIT if WAIT_CYC>0 (counter loaded with WAIT_CYC), else RESP.
- WAIT:
  - rf_enable=0; rf_a/rf_b/rf_w/rf_din hold the latched values.
  - Counter decrements each cycle; leave to RESP in the cycle the counter equals 1.
- RESP:
  - resp_valid=1; resp_op and resp_err stable.
  - Leave to IDLE on resp_ready; hold indefinitely otherwise.
- instr_ready=0 and dbg_grant=0 in EXEC, WAIT and RESP. A held instr_valid is not accepted until the cycle after the response handshake (IDLE).
- Latency, accept at edge N:
  - rf_enable high in cycle N+1.
  - resp_valid first seen in cycle N+2+WAIT_CYC.
  - NOP/reserved: resp_valid in cycle N+1.
- Throughput: at most one LOAD/STORE per 3+WAIT_CYC cycles with resp_ready tied high.
- rf_enable is never high outside EXEC, and never high for more than one consecutive cycle.
- Simultaneous resp_ready and a new instr_valid in RESP: the response completes; the instruction is accepted at the next IDLE edge.
- The sequencer does no address arithmetic. rf forms mem[din+reg[b]]; the sequencer passes imm through unmodified at full DW width.

Optional Feature:
- Macro LS_SEQ_PERF_CNT_EN.
- Defined:
  - Adds outputs cnt_load, cnt_store, cnt_err, 16 bits each.
  - Each increments on the resp_valid&&resp_ready handshake of the matching op (cnt_err for reserved).
  - Saturate at 16'hFFFF; cleared by reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- STORE op=10 rt=2 rb=0 imm=0, WAIT_CYC=1:
  - One cycle after accept: rf_enable=1, rf_load_store=0, rf_a=2, rf_b=0, rf_din=0, for one cycle only.
  - resp_valid 3 cycles after accept; resp_err=0; resp_op=10.
- LOAD op=01 rt=3 rb=21 imm=10 against rf model (rf pre-store so mem[10+reg[21]]=31):
  - rf_load_store=1, rf_w=3, rf_b=21, rf_din=10.
  - After response, in IDLE with dbg_a=3: rf douta=31.
- Reserved op=11:
  - No rf_enable pulse.
  - resp_valid the cycle after accept with resp_err=1 and resp_op=11.
- Backpressure: resp_ready=0 for 5 cycles with a second instr_valid held:
  - resp_valid and fields stay stable; instr_ready=0 throughout.
  - Second instruction accepted exactly one cycle after the resp_ready handshake.
- Reset asserted during WAIT:
  - rf_enable, resp_valid, rf_w, rf_din read 0 immediately.
  - After release: instr_ready=1, dbg_grant=1, no response emitted.
- Debug routing: IDLE with dbg_a=30, dbg_b=31 -> rf_a=30, rf_b=31 in the same cycle. During EXEC/WAIT, dbg_grant=0 and rf_a/rf_b track the instruction, not dbg_a/dbg_b.
